// File: rtl/bank_sched_pkg.sv
// -----------------------------------------------------------------------------
// bank_sched_pkg
// Shared definitions for the two-bank write/read scheduler:
//   AW_DEF / DW_DEF  default address / data widths (AW_DEF mirrors the WIDTH
//                    value of the project parameter file)
//   wbuf_entry_t     one parked write {adr, data}
//   bank_src_t       which request owns a bank in the current cycle
//   bank_of/row_of   address split: bank = adr[0], row = adr[AW-1:1]
// The buffer entry type is sized by AW_DEF/DW_DEF, so width changes are made
// here rather than by overriding module parameters.
// -----------------------------------------------------------------------------
package bank_sched_pkg;

  localparam int AW_DEF = 8;
  localparam int DW_DEF = 32;

  typedef struct packed {
    logic [AW_DEF-1:0] adr;
    logic [DW_DEF-1:0] data;
  } wbuf_entry_t;

  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_READ,
    SRC_HEAD,
    SRC_DIRECT
  } bank_src_t;

  function automatic logic bank_of(input logic [AW_DEF-1:0] adr);
    return adr[0];
  endfunction

  function automatic logic [AW_DEF-2:0] row_of(input logic [AW_DEF-1:0] adr);
    return adr[AW_DEF-1:1];
  endfunction

endpackage

// File: rtl/bank_conflict_sched_if.sv
// -----------------------------------------------------------------------------
// bank_conflict_sched_if
// Request-side bus of the bank scheduler.
//   read : rd_req, rd_adr -> rd_ready ; rd_valid, rd_data one cycle later
//   write: wr_req, wr_adr, wr_data -> wr_ready
// master = requester, slave = scheduler.
// -----------------------------------------------------------------------------
interface bank_conflict_sched_if
  import bank_sched_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) ();

  logic          rd_req;
  logic [AW-1:0] rd_adr;
  logic          rd_ready;
  logic          rd_valid;
  logic [DW-1:0] rd_data;
  logic          wr_req;
  logic [AW-1:0] wr_adr;
  logic [DW-1:0] wr_data;
  logic          wr_ready;

  modport master (
    output rd_req, rd_adr, wr_req, wr_adr, wr_data,
    input  rd_ready, rd_valid, rd_data, wr_ready
  );

  modport slave (
    input  rd_req, rd_adr, wr_req, wr_adr, wr_data,
    output rd_ready, rd_valid, rd_data, wr_ready
  );

endinterface

// File: rtl/wbuf_fifo.sv
// -----------------------------------------------------------------------------
// wbuf_fifo
// In-order write buffer. Entries retire only from the head.
//   clk, rst          clock, synchronous active-high reset (flushes contents)
//   push, push_entry  enqueue at the tail
//   pop               drop the head
//   head              oldest entry (meaningful only when !empty)
//   count, empty      occupancy
//   match_adr         address compared against every occupied entry
//   match_any         some occupied entry holds match_adr
//   match_data        data of the youngest matching entry (only with
//                     BANK_FWD_EN defined)
// DEPTH must be a power of two so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module wbuf_fifo
  import bank_sched_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      push,
  input  wbuf_entry_t               push_entry,
  input  logic                      pop,
  output wbuf_entry_t               head,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      empty,
  input  logic [AW_DEF-1:0]         match_adr,
  output logic                      match_any
`ifdef BANK_FWD_EN
  ,
  output logic [DW_DEF-1:0]         match_data
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  wbuf_entry_t   mem [DEPTH];
  logic [PW-1:0] head_q;
  logic [PW-1:0] tail_q;
  logic [CW-1:0] count_q;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) tail_q <= tail_q + 1'b1;
      if (pop)  head_q <= head_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: ;
      endcase
    end
  end

  // NOTE: the entry storage has no reset; occupancy is defined by the
  // pointers and count, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (push) mem[tail_q] <= push_entry;
  end

  assign head  = mem[head_q];
  assign count = count_q;
  assign empty = (count_q == '0);

  // Walk from oldest to youngest so a later hit overrides an earlier one,
  // leaving the youngest match selected.
  // NOTE: every output of a combinational block gets a default first so no
  // path leaves it unassigned (which would infer a latch).
  always_comb begin
    match_any = 1'b0;
`ifdef BANK_FWD_EN
    match_data = '0;
`endif
    for (int k = 0; k < DEPTH; k++) begin
      logic [PW-1:0] idx;
      idx = head_q + PW'(k);
      if ((CW'(k) < count_q) && (mem[idx].adr == match_adr)) begin
        match_any = 1'b1;
`ifdef BANK_FWD_EN
        match_data = mem[idx].data;
`endif
      end
    end
  end

endmodule

// File: rtl/bank_conflict_sched.sv
// -----------------------------------------------------------------------------
// bank_conflict_sched
// Same-cycle scheduler in front of two single-port RAM banks (bank = adr[0]).
// Reads have priority; writes that lose their bank, or that queue behind older
// parked writes, wait in an in-order buffer. A starvation counter forces the
// buffer head through after STARVE_LIM consecutive blocked cycles.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   bus (slave)         read/write request bus, see bank_conflict_sched_if
//   en_x, we_x, a_x,    bank x enable, write enable, row, write data
//   d_x, q_x            (q_x: registered RAM read data, valid next cycle)
//   wbuf_cnt            occupied write buffer entries
//   conflict_cnt        saturating count of writes that had to be buffered
// Build option BANK_FWD_EN: reads that hit a parked write get the youngest
// parked data instead of stalling until that write retires.
// -----------------------------------------------------------------------------
module bank_conflict_sched
  import bank_sched_pkg::*;
#(
  parameter int AW         = AW_DEF,
  parameter int DW         = DW_DEF,
  parameter int WBUF_DEPTH = 2,
  parameter int STARVE_LIM = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  bank_conflict_sched_if.slave        bus,
  output logic                        en_0,
  output logic                        we_0,
  output logic [AW-2:0]               a_0,
  output logic [DW-1:0]               d_0,
  input  logic [DW-1:0]               q_0,
  output logic                        en_1,
  output logic                        we_1,
  output logic [AW-2:0]               a_1,
  output logic [DW-1:0]               d_1,
  input  logic [DW-1:0]               q_1,
  output logic [$clog2(WBUF_DEPTH):0] wbuf_cnt,
  output logic [15:0]                 conflict_cnt
);

  localparam int CW = $clog2(WBUF_DEPTH) + 1;
  localparam int SW = $clog2(STARVE_LIM + 1);

  wbuf_entry_t   wr_entry;
  wbuf_entry_t   head;
  logic          buf_empty;
  logic          rd_match;
  logic          push;
  logic          pop;

  logic          rd_bank;
  logic          wr_bank;
  logic          head_bank;
  logic          forced;
  logic          rd_acc;
  logic          wr_acc;
  logic          head_blocked;
  logic          direct;
  bank_src_t     src [2];

  logic          bank_en [2];
  logic          bank_we [2];
  logic [AW-2:0] bank_a  [2];
  logic [DW-1:0] bank_d  [2];

  logic [SW-1:0] starve_q;
  logic          rd_valid_q;
  logic          rd_bank_q;
  logic [15:0]   conflict_q;
`ifdef BANK_FWD_EN
  logic [DW-1:0] fwd_data;
  logic          fwd_hit_q;
  logic [DW-1:0] fwd_data_q;
`endif

  assign wr_entry.adr  = bus.wr_adr;
  assign wr_entry.data = bus.wr_data;

  wbuf_fifo #(
    .DEPTH (WBUF_DEPTH)
  ) u_wbuf (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_entry (wr_entry),
    .pop        (pop),
    .head       (head),
    .count      (wbuf_cnt),
    .empty      (buf_empty),
    .match_adr  (bus.rd_adr),
    .match_any  (rd_match)
`ifdef BANK_FWD_EN
    ,
    .match_data (fwd_data)
`endif
  );

  // Arbitration. A forced head shuts reads out of its bank through rd_ready,
  // so "forced head beats read" falls out of the ordinary read-vs-head rule.
  always_comb begin
    rd_bank   = bank_of(bus.rd_adr);
    wr_bank   = bank_of(bus.wr_adr);
    head_bank = bank_of(head.adr);
    forced    = !buf_empty && (starve_q == SW'(STARVE_LIM));

    bus.rd_ready = !rst && !(forced && (rd_bank == head_bank));
`ifndef BANK_FWD_EN
    // Without forwarding a read may not overtake a parked write to its address.
    if (rd_match) bus.rd_ready = 1'b0;
`endif
    // Deliberately ignores a same-cycle retire so the ready path stays short.
    bus.wr_ready = !rst && (wbuf_cnt < CW'(WBUF_DEPTH));

    rd_acc       = bus.rd_req && bus.rd_ready;
    wr_acc       = bus.wr_req && bus.wr_ready;
    head_blocked = !buf_empty && rd_acc && (rd_bank == head_bank);
    pop          = !rst && !buf_empty && !head_blocked;
    // Direct issue only with an empty buffer, so at most one write per cycle.
    direct       = wr_acc && buf_empty && !(rd_acc && (rd_bank == wr_bank));
    push         = wr_acc && !direct;

    for (int b = 0; b < 2; b++) begin
      src[b] = SRC_NONE;
      if (rd_acc && (rd_bank == 1'(b)))         src[b] = SRC_READ;
      else if (pop && (head_bank == 1'(b)))     src[b] = SRC_HEAD;
      else if (direct && (wr_bank == 1'(b)))    src[b] = SRC_DIRECT;
    end
  end

  always_comb begin
    for (int b = 0; b < 2; b++) begin
      bank_en[b] = 1'b0;
      bank_we[b] = 1'b0;
      bank_a[b]  = '0;
      bank_d[b]  = '0;
      case (src[b])
        SRC_READ: begin
          bank_en[b] = 1'b1;
          bank_a[b]  = row_of(bus.rd_adr);
        end
        SRC_HEAD: begin
          bank_en[b] = 1'b1;
          bank_we[b] = 1'b1;
          bank_a[b]  = row_of(head.adr);
          bank_d[b]  = head.data;
        end
        SRC_DIRECT: begin
          bank_en[b] = 1'b1;
          bank_we[b] = 1'b1;
          bank_a[b]  = row_of(bus.wr_adr);
          bank_d[b]  = bus.wr_data;
        end
        default: ;
      endcase
    end
  end

  assign en_0 = bank_en[0];
  assign we_0 = bank_we[0];
  assign a_0  = bank_a[0];
  assign d_0  = bank_d[0];
  assign en_1 = bank_en[1];
  assign we_1 = bank_we[1];
  assign a_1  = bank_a[1];
  assign d_1  = bank_d[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_q   <= '0;
      rd_valid_q <= 1'b0;
      rd_bank_q  <= 1'b0;
      conflict_q <= '0;
`ifdef BANK_FWD_EN
      fwd_hit_q  <= 1'b0;
      fwd_data_q <= '0;
`endif
    end else begin
      // Counts consecutive cycles the head lost its bank to a read.
      if (buf_empty || pop)  starve_q <= '0;
      else if (head_blocked) starve_q <= starve_q + 1'b1;

      rd_valid_q <= rd_acc;
      if (rd_acc) rd_bank_q <= rd_bank;

      if (push && (conflict_q != 16'hFFFF)) conflict_q <= conflict_q + 1'b1;
`ifdef BANK_FWD_EN
      fwd_hit_q <= rd_acc && rd_match;
      if (rd_acc && rd_match) fwd_data_q <= fwd_data;
`endif
    end
  end

  always_comb begin
    bus.rd_data = '0;
    if (rd_valid_q) begin
      bus.rd_data = rd_bank_q ? q_1 : q_0;
`ifdef BANK_FWD_EN
      // The bank was still read; its data is discarded in favour of the
      // parked write captured at acceptance.
      if (fwd_hit_q) bus.rd_data = fwd_data_q;
`endif
    end
  end

  assign bus.rd_valid = rd_valid_q;
  assign conflict_cnt = conflict_q;

endmodule

// File: tb/tb_bank_conflict_sched.sv
// -----------------------------------------------------------------------------
// tb_bank_conflict_sched
// Directed scenarios followed by random traffic. A reference model built on a
// queue of parked writes plus "latest accepted" and "committed" memory images
// predicts readiness, per-bank activity, occupancy, conflict count and read
// data. Two behavioural RAM banks sit on the bank ports.
// -----------------------------------------------------------------------------
module tb_bank_conflict_sched;
  import bank_sched_pkg::*;

  localparam int AW    = AW_DEF;
  localparam int DW    = DW_DEF;
  localparam int DEPTH = 2;
  localparam int LIM   = 4;
  localparam int NADR  = 1 << AW;
  localparam int NROW  = NADR / 2;
`ifdef BANK_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bank_conflict_sched_if bus ();

  logic                     en_0, we_0, en_1, we_1;
  logic [AW-2:0]            a_0, a_1;
  logic [DW-1:0]            d_0, d_1;
  logic [DW-1:0]            q_0 = '0;
  logic [DW-1:0]            q_1 = '0;
  logic [$clog2(DEPTH):0]   wbuf_cnt;
  logic [15:0]              conflict_cnt;

  bank_conflict_sched #(
    .AW (AW), .DW (DW), .WBUF_DEPTH (DEPTH), .STARVE_LIM (LIM)
  ) dut (
    .clk (clk), .rst (rst), .bus (bus),
    .en_0 (en_0), .we_0 (we_0), .a_0 (a_0), .d_0 (d_0), .q_0 (q_0),
    .en_1 (en_1), .we_1 (we_1), .a_1 (a_1), .d_1 (d_1), .q_1 (q_1),
    .wbuf_cnt (wbuf_cnt), .conflict_cnt (conflict_cnt)
  );

  // Behavioural RAM banks with registered read data.
  logic [DW-1:0] ram0 [NROW] = '{default: '0};
  logic [DW-1:0] ram1 [NROW] = '{default: '0};
  always @(posedge clk) begin
    if (en_0) begin
      if (we_0) ram0[a_0] <= d_0;
      else      q_0 <= ram0[a_0];
    end
    if (en_1) begin
      if (we_1) ram1[a_1] <= d_1;
      else      q_1 <= ram1[a_1];
    end
  end

  // Reference model state.
  typedef struct {
    logic [AW-1:0] adr;
    logic [DW-1:0] data;
  } wr_t;
  wr_t           wq [$];
  int            starve;
  int            conflicts;
  logic [DW-1:0] arch   [NADR];
  logic [DW-1:0] commit [NADR];
  bit            prev_racc;
  logic [DW-1:0] prev_exp;
  bit            last_racc;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, compare at the falling edge, advance model.
  task automatic step(input bit r, input bit rr, input logic [AW-1:0] ra,
                      input bit wr, input logic [AW-1:0] wa, input logic [DW-1:0] wd);
    bit            has, hb, forced, match, e_rrdy, e_wrdy, racc, wacc, retire, direct;
    bit [1:0]      e_ctl [2];
    logic [AW-2:0] e_a   [2];
    logic [DW-1:0] e_d   [2];
    @(posedge clk);
    #1;
    rst         = r;
    bus.rd_req  = rr;
    bus.rd_adr  = ra;
    bus.wr_req  = wr;
    bus.wr_adr  = wa;
    bus.wr_data = wd;
    @(negedge clk);

    check("rd_valid", bus.rd_valid, prev_racc);
    if (prev_racc) check("rd_data", bus.rd_data, prev_exp);
    check("wbuf_cnt", wbuf_cnt, wq.size());
    check("conflict_cnt", conflict_cnt, conflicts);

    has    = (wq.size() > 0);
    hb     = has ? wq[0].adr[0] : 1'b0;
    forced = has && (starve == LIM);
    match  = 1'b0;
    foreach (wq[i]) if (wq[i].adr == ra) match = 1'b1;
    if (r) begin
      e_rrdy = 1'b0;
      e_wrdy = 1'b0;
    end else begin
      e_rrdy = !(forced && (ra[0] == hb)) && (FWD || !match);
      e_wrdy = (wq.size() < DEPTH);
    end
    racc   = rr && e_rrdy;
    wacc   = wr && e_wrdy;
    retire = !r && has && !(racc && (ra[0] == hb));
    direct = wacc && !has && !(racc && (ra[0] == wa[0]));

    for (int b = 0; b < 2; b++) begin
      e_ctl[b] = 2'b00;
      e_a[b]   = '0;
      e_d[b]   = '0;
      if (racc && (ra[0] == b[0])) begin
        e_ctl[b] = 2'b10;
        e_a[b]   = ra[AW-1:1];
      end else if (retire && (hb == b[0])) begin
        e_ctl[b] = 2'b11;
        e_a[b]   = wq[0].adr[AW-1:1];
        e_d[b]   = wq[0].data;
      end else if (direct && (wa[0] == b[0])) begin
        e_ctl[b] = 2'b11;
        e_a[b]   = wa[AW-1:1];
        e_d[b]   = wd;
      end
    end

    check("rd_ready", bus.rd_ready, e_rrdy);
    check("wr_ready", bus.wr_ready, e_wrdy);
    check("bank0_en_we", {en_0, we_0}, e_ctl[0]);
    check("bank1_en_we", {en_1, we_1}, e_ctl[1]);
    if (e_ctl[0][1]) check("bank0_row", a_0, e_a[0]);
    if (e_ctl[1][1]) check("bank1_row", a_1, e_a[1]);
    if (e_ctl[0] == 2'b11) check("bank0_wdata", d_0, e_d[0]);
    if (e_ctl[1] == 2'b11) check("bank1_wdata", d_1, e_d[1]);

    if (r) begin
      wq.delete();
      starve    = 0;
      conflicts = 0;
      prev_racc = 1'b0;
      arch      = commit;
    end else begin
      prev_racc = racc;
      if (racc) prev_exp = arch[ra];
      if (retire) begin
        commit[wq[0].adr] = wq[0].data;
        void'(wq.pop_front());
        starve = 0;
      end else if (has) begin
        starve++;
      end else begin
        starve = 0;
      end
      if (direct) commit[wa] = wd;
      if (wacc) begin
        arch[wa] = wd;
        if (!direct) begin
          wq.push_back('{adr: wa, data: wd});
          if (conflicts < 65535) conflicts++;
        end
      end
    end
    last_racc = racc;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, '0, 1'b0, '0, '0);
  endtask

  initial begin
    for (int i = 0; i < NADR; i++) begin
      arch[i]   = '0;
      commit[i] = '0;
    end
    starve      = 0;
    conflicts   = 0;
    prev_racc   = 1'b0;
    prev_exp    = '0;
    last_racc   = 1'b0;
    rst         = 1'b1;
    bus.rd_req  = 1'b0;
    bus.rd_adr  = '0;
    bus.wr_req  = 1'b0;
    bus.wr_adr  = '0;
    bus.wr_data = '0;
    @(posedge clk);

    // Reset state: outputs forced low, counters clear.
    step(1'b1, 1'b1, 8'h00, 1'b1, 8'h02, 32'h1);
    check("reset_rd_ready", bus.rd_ready, 1'b0);
    check("reset_wr_ready", bus.wr_ready, 1'b0);
    step(1'b1, 1'b0, '0, 1'b0, '0, '0);
    idle();

    // Direct write on an empty buffer.
    step(1'b0, 1'b0, '0, 1'b1, 8'h04, 32'hA5A5_0004);
    check("direct_en_we0", {en_0, we_0}, 2'b11);
    check("direct_row0", a_0, 2);

    // Read and write on bank 0 together: write parks, retires next cycle.
    step(1'b0, 1'b1, 8'h06, 1'b1, 8'h08, 32'h0000_0808);
    check("rw_read_wins", {en_0, we_0}, 2'b10);
    idle();
    check("park_wbuf_cnt", wbuf_cnt, 1);
    check("park_conflict", conflict_cnt, 1);
    check("retire_row0", a_0, 4);
    check("retire_we0", we_0, 1'b1);

    // Sustained bank-0 reads: fill the buffer, then the head is forced.
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 1'b1, 8'h00, 1'b1, (i == 0) ? 8'h0A : ((i == 1) ? 8'h0C : 8'h0E),
           32'h0BAD_0000 + i);
      if (i == 2) check("full_wr_ready", bus.wr_ready, 1'b0);
    end
    check("forced_rd_ready", bus.rd_ready, 1'b0);
    check("forced_we0", we_0, 1'b1);
    check("forced_row0", a_0, 5);
    repeat (3) idle();

    // Read hitting a parked write.
    step(1'b0, 1'b1, 8'h12, 1'b1, 8'h10, 32'hDEAD_BEEF);
    step(1'b0, 1'b1, 8'h10, 1'b0, '0, '0);
    check("hazard_rd_ready", bus.rd_ready, FWD);
    for (int k = 0; k < 4 && !last_racc; k++) step(1'b0, 1'b1, 8'h10, 1'b0, '0, '0);
    idle();
    check("hit_rd_valid", bus.rd_valid, 1'b1);
    check("hit_rd_data", bus.rd_data, 32'hDEAD_BEEF);

    // Two parked writes to one address retire in order.
    step(1'b0, 1'b1, 8'h01, 1'b1, 8'h03, 32'h11);
    step(1'b0, 1'b1, 8'h05, 1'b1, 8'h03, 32'h22);
    idle();
    check("order_first_d1", d_1, 32'h11);
    check("order_first_row1", a_1, 1);
    idle();
    check("order_second_d1", d_1, 32'h22);
    step(1'b0, 1'b1, 8'h03, 1'b0, '0, '0);
    idle();
    check("order_read_back", bus.rd_data, 32'h22);

    // Reset with a full buffer and a read in flight.
    step(1'b0, 1'b1, 8'h00, 1'b1, 8'h20, 32'h2020);
    step(1'b0, 1'b1, 8'h00, 1'b1, 8'h22, 32'h2222);
    step(1'b1, 1'b1, 8'h00, 1'b0, '0, '0);
    check("rst_bank_en", {en_0, en_1}, 2'b00);
    idle();
    check("post_rst_cnt", wbuf_cnt, 0);
    check("post_rst_valid", bus.rd_valid, 1'b0);
    check("post_rst_we", {we_0, we_1}, 2'b00);
    repeat (2) idle();

    // Random traffic over a small address window to provoke conflicts.
    for (int n = 0; n < 600; n++) begin
      step(($urandom_range(0, 199) == 0),
           ($urandom_range(0, 3) != 0), AW'($urandom_range(0, 15)),
           ($urandom_range(0, 2) != 0), AW'($urandom_range(0, 15)),
           $urandom());
    end
    repeat (8) idle();

    // Every committed write must have landed in the RAM banks.
    for (int i = 0; i < 16; i++) begin
      logic [AW-1:0] adr;
      adr = AW'(i);
      check("ram_final", adr[0] ? ram1[adr[AW-1:1]] : ram0[adr[AW-1:1]], commit[adr]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bank_conflict_sched.md
Name: bank_conflict_sched

Overview:
- Scheduler in front of the two-bank single-port RAM pair.
- Bank is selected by address LSB; row is the upper address bits.
- Accepts one read and one write request per cycle.
- Reads get priority. A write that loses its bank, or arrives behind older writes, is parked in a small in-order write buffer and retired when its bank is free.
- A starvation guard ensures buffered writes eventually win against sustained reads.

Parameters:
- AW, `WIDTH from param_define.v — full address width; bank = adr[0], row = adr[AW-1:1].
- DW, 32 — data width.
- WBUF_DEPTH, 2 — write buffer entries (power of two, ≥2).
- STARVE_LIM, 4 — consecutive blocked cycles of the buffer head before it preempts reads.

Ports:
- clk  in  1  — clock.
- rst  in  1  — synchronous active-high reset.
- rd_req  in  1  — read request.
- rd_adr  in  AW  — read address.
- rd_ready  out  1  — read accepted this cycle when rd_req & rd_ready.
- rd_valid  out  1  — read data valid, one cycle after acceptance.
- rd_data  out  DW  — read data.
- wr_req  in  1  — write request.
- wr_adr  in  AW  — write address.
- wr_data  in  DW  — write data.
- wr_ready  out  1  — write accepted when wr_req & wr_ready.
- en_0 / we_0  out  1  — bank 0 enable / write enable.
- a_0  out  AW-1  — bank 0 row.
- d_0  out  DW  — bank 0 write data.
- q_0  in  DW  — bank 0 read data, registered by RAM, valid the cycle after en_0 & ~we_0.
- en_1, we_1, a_1, d_1, q_1 — same as above for bank 1.
- wbuf_cnt  out  $clog2(WBUF_DEPTH)+1  — occupied buffer entries.
- conflict_cnt  out  16  — saturating count of writes that were buffered instead of issued directly.

Behaviour:
- Reset (rst high at clk edge):
  - Buffer flushed; pending writes are discarded.
  - rd_valid=0, rd_data=0, wbuf_cnt=0, conflict_cnt=0, starve counter=0.
  - While rst is high, all bank outputs, rd_ready and wr_ready are forced to 0.
- Bank outputs are combinational from the current inputs and buffer state (same-cycle issue). At most one operation per bank per cycle, and at most one write issued per cycle.
- Per-bank priority each cycle:
  1. Forced head write (starve counter == STARVE_LIM).
  2. Accepted read.
  3. Buffer head write.
  4. Incoming write, direct issue.
- rd_ready = ~(starve forced && rd_adr[0] == head bank), further gated by the hazard rule under Optional Feature.
- Write path:
  - wr_ready = (wbuf_cnt < WBUF_DEPTH). It does not look ahead at a same-cycle retire.
  - An accepted write issues directly only if the buffer is empty and its bank is not taken by an accepted read.
  - Otherwise it is enqueued at the tail and conflict_cnt increments, saturating at 16'hFFFF.
  - Only the head may retire, so writes retire strictly in acceptance order.
  - Head retire and enqueue in the same cycle are both allowed; wbuf_cnt stays unchanged.
- Starvation:
  - The counter increments each cycle a non-empty head is blocked by a read, and clears on head retire or when the buffer is empty.
  - At STARVE_LIM the head issues unconditionally and reads to that bank see rd_ready=0 for that cycle.
- Read path:
  - An accepted read drives en=1, we=0, a=row on bank rd_adr[0].
  - Bank bit and forward state are registered; next cycle rd_valid=1 and rd_data = q of that bank, or the forwarded value.
  - rd_valid is 0 in any cycle without a read accepted the previous cycle.
- Same-cycle read and write to the same address: the read returns the old (pre-write) data.
- Reset mid-operation: a read accepted in the reset cycle produces no rd_valid.

Optional Feature:
- Macro BANK_FWD_EN.
- Defined:
  - An accepted read whose address matches one or more buffered entries returns the youngest match's data at rd_valid, captured at acceptance.
  - The bank read is still issued and its data is ignored.
  - rd_ready is unaffected by buffer contents.
- Undefined:
  - rd_ready=0 while rd_adr matches any buffered entry; the read stalls until the entry retires.
  - No match comparators are used on the data path.

Decomposition:
- Package bank_sched_pkg holds: AW/DW defaults, bank_of() and row_of() helper functions, and the buffer entry struct {adr, data}.
- One sub-module, wbuf_fifo: in-order FIFO with head/tail pointers, count, and per-entry address-match vector with youngest-match select.

Test Plan:
- Write 0x04 (bank 0) with buffer empty and no read → en_0=we_0=1, a_0=0x02 same cycle; conflict_cnt stays 0.
- Read 0x06 and write 0x08 in the same cycle (both bank 0) → read issued, write buffered, wbuf_cnt=1, conflict_cnt=1; next cycle the head retires on bank 0 (en_0=we_0=1, a_0=0x04).
- Buffer full (WBUF_DEPTH=2) with reads held on the head's bank → wr_ready=0. After 4 blocked cycles the head is forced: we_0=1, rd_ready=0 for bank-0 reads.
- BANK_FWD_EN defined: buffered write 0x10←0xDEADBEEF, then read 0x10 → rd_valid next cycle with rd_data=0xDEADBEEF. Undefined: rd_ready=0 until retire, then the read returns 0xDEADBEEF from RAM.
- Two buffered writes to 0x03 (0x11 then 0x22) → bank 1 sees 0x11 then 0x22 in order; final read returns 0x22.
- rst asserted with 2 entries buffered and a read in flight → next cycle wbuf_cnt=0, rd_valid=0, no further we_x pulses.
